// File: rtl/cfg_init_pkg.sv
// Shared definitions for the power-up register-init sequencer:
// FSM state encoding, default bus widths and table entry packing.
package cfg_init_pkg;

    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned DATA_W_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARMED     = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_ISSUE     = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_GAP       = 3'd5,
        ST_DONE      = 3'd6,
        ST_ERROR     = 3'd7
    } state_t;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } entry_t;

    function automatic entry_t pack_entry(input logic [ADDR_W_DEF-1:0] addr,
                                          input logic [DATA_W_DEF-1:0] data);
        entry_t e;
        e.addr = addr;
        e.data = data;
        return e;
    endfunction

    // clog2 with a floor of 1 bit so single-entry/single-cycle cases still get a register
    function automatic int unsigned width_of(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/cfg_init_if.sv
// Request/completion channel between the init sequencer (master) and the
// downstream serial write master (slave).
interface cfg_init_if
    import cfg_init_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
);
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_done;
    logic              wr_ack_ok;

    modport master (
        output wr_valid, wr_addr, wr_data,
        input  wr_ready, wr_done, wr_ack_ok
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data,
        output wr_ready, wr_done, wr_ack_ok
    );

endinterface

// File: rtl/cfg_init_rom.sv
// Fixed power-up register table: entry index -> {addr, data}.
// Out-of-range indices return entry 0.
module cfg_init_rom
    import cfg_init_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned NUM_WR = 16,
    parameter int unsigned IDX_W  = width_of(NUM_WR)
) (
    input  logic [IDX_W-1:0]  idx,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);

    logic [31:0] sel;
    entry_t      entry;

    always_comb begin
        sel   = (32'(idx) < NUM_WR) ? 32'(idx) : 32'd0;
        entry = '0;
        case (sel)
            32'd0:   entry = pack_entry(8'h01, 16'h00A5);
            32'd1:   entry = pack_entry(8'h02, 16'h1234);
            32'd2:   entry = pack_entry(8'h10, 16'hBEEF);
            32'd3:   entry = pack_entry(8'h11, 16'h0F0F);
            32'd4:   entry = pack_entry(8'h12, 16'h8001);
            32'd5:   entry = pack_entry(8'h20, 16'h0040);
            32'd6:   entry = pack_entry(8'h21, 16'hC0DE);
            32'd7:   entry = pack_entry(8'h22, 16'h7FFF);
            32'd8:   entry = pack_entry(8'h30, 16'h0001);
            32'd9:   entry = pack_entry(8'h31, 16'hA5A5);
            32'd10:  entry = pack_entry(8'h40, 16'h5A5A);
            32'd11:  entry = pack_entry(8'h41, 16'h0000);
            32'd12:  entry = pack_entry(8'h50, 16'hFFFF);
            32'd13:  entry = pack_entry(8'h51, 16'h1357);
            32'd14:  entry = pack_entry(8'h60, 16'h2468);
            32'd15:  entry = pack_entry(8'h7F, 16'h0003);
            default: entry = '0;
        endcase
        addr = ADDR_W'(entry.addr);
        data = DATA_W'(entry.data);
    end

endmodule

// File: rtl/cfg_init_seq.sv
// Power-up register-init sequencer: after slow_rst releases, settles, then
// issues each table entry to the serial write master with retry/timeout.
module cfg_init_seq
    import cfg_init_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned NUM_WR     = 16,
    parameter int unsigned SETTLE_CYC = 1000,
    parameter int unsigned GAP_CYC    = 64,
    parameter int unsigned TMO_CYC    = 4096,
    parameter int unsigned MAX_RETRY  = 2,
    localparam int unsigned IDX_W     = width_of(NUM_WR)
) (
    input  logic             clk,
    input  logic             reset_sync,
    input  logic             slow_rst,
    cfg_init_if.master       wr,
    output logic             init_busy,
    output logic             init_done,
    output logic             init_err,
    output logic [IDX_W-1:0] err_idx
);

    localparam int unsigned CNT_W = width_of(max3(SETTLE_CYC, GAP_CYC, TMO_CYC));
    localparam int unsigned RTY_W = width_of(MAX_RETRY + 1);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'((GAP_CYC == 0) ? 0 : GAP_CYC - 1);
    localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(TMO_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_WR - 1);
    localparam logic [RTY_W-1:0] RETRY_MAX   = RTY_W'(MAX_RETRY);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [RTY_W-1:0] retry_q, retry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] err_idx_q, err_idx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             fail;
    logic             issue;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;

    cfg_init_rom #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .NUM_WR (NUM_WR),
        .IDX_W  (IDX_W)
    ) u_rom (
        .idx  (idx_q),
        .addr (rom_addr),
        .data (rom_data)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        retry_d   = retry_q;
        cnt_d     = cnt_q;
        err_idx_d = err_idx_q;
        fail      = 1'b0;

        if (slow_rst) begin
            state_d   = ST_ARMED;
            idx_d     = '0;
            retry_d   = '0;
            cnt_d     = '0;
            err_idx_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                end
                ST_ARMED: begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                end
                ST_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) state_d = ST_ISSUE;
                    else                      cnt_d   = cnt_q + 1'b1;
                end
                ST_ISSUE: begin
                    if (wr.wr_ready) begin
                        state_d = ST_WAIT_DONE;
                        cnt_d   = '0;
                    end
                end
                ST_WAIT_DONE: begin
                    // a completion arriving in the timeout cycle takes priority
                    if (wr.wr_done) begin
                        if (wr.wr_ack_ok) begin
                            retry_d = '0;
                            if (idx_q == IDX_LAST) begin
                                state_d = ST_DONE;
                            end else begin
                                idx_d   = idx_q + 1'b1;
                                cnt_d   = '0;
                                state_d = (GAP_CYC == 0) ? ST_ISSUE : ST_GAP;
                            end
                        end else begin
                            fail = 1'b1;
                        end
                    end else if (cnt_q == TMO_LAST) begin
                        fail = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (cnt_q == GAP_LAST) state_d = ST_ISSUE;
                    else                   cnt_d   = cnt_q + 1'b1;
                end
                ST_DONE, ST_ERROR: begin
                end
                default: state_d = ST_IDLE;
            endcase

            if (fail) begin
                if (retry_q < RETRY_MAX) begin
                    retry_d = retry_q + 1'b1;
                    state_d = ST_ISSUE;
                end else begin
                    state_d   = ST_ERROR;
                    err_idx_d = idx_q;
                end
            end
        end

        // status tracks the state being entered, so it lines up with the state register
        busy_d = (state_d == ST_SETTLE) || (state_d == ST_ISSUE) ||
                 (state_d == ST_WAIT_DONE) || (state_d == ST_GAP);
        done_d = (state_d == ST_DONE);
        err_d  = (state_d == ST_ERROR);
    end

    always_ff @(posedge clk) begin
        if (reset_sync) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            retry_q   <= '0;
            cnt_q     <= '0;
            err_idx_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            retry_q   <= retry_d;
            cnt_q     <= cnt_d;
            err_idx_q <= err_idx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        issue       = (state_q == ST_ISSUE);
        wr.wr_valid = issue;
        wr.wr_addr  = issue ? rom_addr : '0;
        wr.wr_data  = issue ? rom_data : '0;
        init_busy   = busy_q;
        init_done   = done_q;
        init_err    = err_q;
        err_idx     = err_idx_q;
    end

endmodule

// File: tb/tb_cfg_init_seq.sv
// Scoreboard bench for cfg_init_seq with a small serial-master responder model.
module tb_cfg_init_seq;

    localparam int unsigned NUM_WR   = 4;
    localparam int RSP_ACK  = 0;
    localparam int RSP_NACK = 1;
    localparam int RSP_NONE = 2;

    logic       clk = 1'b0;
    logic       reset_sync;
    logic       slow_rst;
    logic       init_busy;
    logic       init_done;
    logic       init_err;
    logic [1:0] err_idx;

    cfg_init_if #(.ADDR_W(8), .DATA_W(16)) wr_if ();

    cfg_init_seq #(
        .ADDR_W     (8),
        .DATA_W     (16),
        .NUM_WR     (NUM_WR),
        .SETTLE_CYC (10),
        .GAP_CYC    (3),
        .TMO_CYC    (20),
        .MAX_RETRY  (2)
    ) dut (
        .clk        (clk),
        .reset_sync (reset_sync),
        .slow_rst   (slow_rst),
        .wr         (wr_if),
        .init_busy  (init_busy),
        .init_done  (init_done),
        .init_err   (init_err),
        .err_idx    (err_idx)
    );

    always #5 clk = ~clk;

    logic [7:0]  exp_addr [4] = '{8'h01, 8'h02, 8'h10, 8'h11};
    logic [15:0] exp_data [4] = '{16'h00A5, 16'h1234, 16'hBEEF, 16'h0F0F};

    int checks   = 0;
    int failures = 0;

    int exp_q[$];
    int resp_q[$];
    int hs_cyc[$];
    int ready_low   = 0;
    int hs_cnt      = 0;
    int done_pulses = 0;
    int valid_cnt   = 0;
    int force_done  = 0;
    int cyc         = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // serial master model: ready after ready_low cycles, done 5 cycles after accept
    initial begin
        int   e;
        int   rsp;
        int   done_cnt;
        int   low_left;
        bit   pend_ack;
        bit   in_req;
        logic [7:0]  cap_a;
        logic [15:0] cap_d;
        done_cnt = 0;
        low_left = 0;
        pend_ack = 1'b0;
        in_req   = 1'b0;
        cap_a    = '0;
        cap_d    = '0;
        wr_if.wr_ready  = 1'b0;
        wr_if.wr_done   = 1'b0;
        wr_if.wr_ack_ok = 1'b0;
        forever begin
            @(negedge clk);
            wr_if.wr_done   = 1'b0;
            wr_if.wr_ack_ok = 1'b0;
            wr_if.wr_ready  = 1'b0;
            if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0) begin
                    wr_if.wr_done   = 1'b1;
                    wr_if.wr_ack_ok = pend_ack;
                    done_pulses++;
                end
            end
            if (force_done != 0) begin
                force_done      = 0;
                wr_if.wr_done   = 1'b1;
                wr_if.wr_ack_ok = 1'b1;
            end
            if (wr_if.wr_valid) valid_cnt++;
            if (slow_rst || reset_sync) begin
                in_req = 1'b0;
            end else begin
                if (in_req) check("hold_valid", wr_if.wr_valid, 1);
                if (wr_if.wr_valid) begin
                    if (!in_req) begin
                        in_req   = 1'b1;
                        low_left = ready_low;
                        cap_a    = wr_if.wr_addr;
                        cap_d    = wr_if.wr_data;
                    end else begin
                        check("hold_addr", wr_if.wr_addr, cap_a);
                        check("hold_data", wr_if.wr_data, cap_d);
                    end
                    if (low_left > 0) begin
                        low_left--;
                    end else begin
                        wr_if.wr_ready = 1'b1;
                        in_req = 1'b0;
                        hs_cnt++;
                        hs_cyc.push_back(cyc + 1);
                        check("sb_pending", exp_q.size() != 0, 1);
                        if (exp_q.size() != 0) begin
                            e = exp_q.pop_front();
                            check("wr_addr", wr_if.wr_addr, exp_addr[e]);
                            check("wr_data", wr_if.wr_data, exp_data[e]);
                        end
                        rsp = (resp_q.size() != 0) ? resp_q.pop_front() : RSP_ACK;
                        if (rsp != RSP_NONE) begin
                            done_cnt = 5;
                            pend_ack = (rsp == RSP_ACK);
                        end
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_all();
        for (int i = 0; i < int'(NUM_WR); i++) exp_q.push_back(i);
    endtask

    task automatic release_measure(output int lat);
        slow_rst = 1'b0;
        lat = 0;
        while (!wr_if.wr_valid && lat < 100) begin
            tick(1);
            lat++;
        end
    endtask

    task automatic start_seq(input int hold, output int lat);
        slow_rst = 1'b1;
        tick(hold);
        check("armed_busy", init_busy, 0);
        check("armed_done", init_done, 0);
        release_measure(lat);
    endtask

    task automatic wait_end(input int max_cyc);
        int n;
        n = 0;
        while (!(init_done || init_err) && n < max_cyc) begin
            tick(1);
            n++;
        end
        check("end_reached", init_done | init_err, 1);
    endtask

    initial begin
        int lat;
        int vc;
        int n;
        reset_sync = 1'b1;
        slow_rst   = 1'b0;
        tick(3);
        check("rst_outs", {wr_if.wr_valid, wr_if.wr_addr, wr_if.wr_data,
                           init_busy, init_done, init_err, err_idx}, 0);
        reset_sync = 1'b0;
        tick(20);
        check("idle_no_issue", valid_cnt, 0);
        check("idle_busy", init_busy, 0);

        // 1: nominal sequence
        hs_cyc.delete();
        push_all();
        start_seq(32, lat);
        check("t1_latency", lat, 11);
        check("t1_busy", init_busy, 1);
        wait_end(600);
        check("t1_done", init_done, 1);
        check("t1_err", init_err, 0);
        check("t1_sb_left", exp_q.size(), 0);
        check("t1_hs_count", hs_cyc.size(), 4);
        for (int i = 0; i + 1 < hs_cyc.size(); i++)
            check("t1_hs_spacing", hs_cyc[i+1] - hs_cyc[i], 9);
        tick(1);
        check("t1_idle_busy", init_busy, 0);

        // 2: slow acceptance, request held stable
        ready_low = 7;
        push_all();
        start_seq(4, lat);
        check("t2_latency", lat, 11);
        wait_end(800);
        check("t2_done", init_done, 1);
        check("t2_sb_left", exp_q.size(), 0);
        ready_low = 0;

        // 3: entry 2 NACKed twice then ACKed
        hs_cnt = 0;
        foreach (exp_addr[i]) begin
            exp_q.push_back(i);
            if (i == 2) begin
                exp_q.push_back(2);
                exp_q.push_back(2);
            end
        end
        resp_q = '{RSP_ACK, RSP_ACK, RSP_NACK, RSP_NACK, RSP_ACK, RSP_ACK};
        start_seq(4, lat);
        wait_end(800);
        check("t3_done", init_done, 1);
        check("t3_err", init_err, 0);
        check("t3_issues", hs_cnt, 6);
        check("t3_sb_left", exp_q.size(), 0);

        // 4: entry 1 never completes
        hs_cyc.delete();
        exp_q  = '{0, 1, 1, 1};
        resp_q = '{RSP_ACK, RSP_NONE, RSP_NONE, RSP_NONE};
        start_seq(4, lat);
        wait_end(800);
        check("t4_err", init_err, 1);
        check("t4_err_idx", err_idx, 1);
        check("t4_done", init_done, 0);
        check("t4_busy", init_busy, 0);
        check("t4_hs_count", hs_cyc.size(), 4);
        if (hs_cyc.size() >= 4) begin
            check("t4_tmo_1", hs_cyc[2] - hs_cyc[1], 21);
            check("t4_tmo_2", hs_cyc[3] - hs_cyc[2], 21);
        end
        vc = valid_cnt;
        force_done = 1;
        tick(5);
        check("t4_late_err", init_err, 1);
        check("t4_late_idx", err_idx, 1);
        check("t4_late_done", init_done, 0);
        check("t4_late_valid", valid_cnt, vc);
        check("t4_sb_left", exp_q.size(), 0);

        // 5: slow_rst during WAIT_DONE of entry 2
        hs_cnt = 0;
        exp_q  = '{0, 1, 2};
        start_seq(4, lat);
        n = 0;
        while (hs_cnt < 3 && n < 300) begin
            tick(1);
            n++;
        end
        check("t5_reached_e2", hs_cnt, 3);
        tick(1);
        slow_rst = 1'b1;
        tick(1);
        check("t5_valid_off", wr_if.wr_valid, 0);
        check("t5_busy_off", init_busy, 0);
        tick(9);
        check("t5_held_done", init_done, 0);
        check("t5_held_err", init_err, 0);
        push_all();
        release_measure(lat);
        check("t5_latency", lat, 11);
        wait_end(600);
        check("t5_done", init_done, 1);
        check("t5_sb_left", exp_q.size(), 0);

        // 6: reset_sync during GAP
        exp_q.push_back(0);
        start_seq(4, lat);
        n = done_pulses;
        vc = 0;
        while (done_pulses == n && vc < 100) begin
            tick(1);
            vc++;
        end
        reset_sync = 1'b1;
        tick(1);
        check("t6_rst_outs", {wr_if.wr_valid, wr_if.wr_addr, wr_if.wr_data,
                              init_busy, init_done, init_err, err_idx}, 0);
        reset_sync = 1'b0;
        vc = valid_cnt;
        tick(30);
        check("t6_idle_valid", valid_cnt, vc);
        check("t6_idle_busy", init_busy, 0);
        check("t6_sb_left", exp_q.size(), 0);
        push_all();
        start_seq(4, lat);
        check("t6_latency", lat, 11);
        wait_end(600);
        check("t6_done", init_done, 1);
        check("t6_sb_end", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
